// File: rtl/seven_seg_rx_if.sv
// Bundle of the seven-segment bus and the decoded-frame outputs of seven_seg_rx.
// The display side drives seg_in (master); the decoder consumes it (slave).
interface seven_seg_rx_if;
  logic [7:0] seg_in;
  logic [7:0] value;
  logic       value_valid;
  logic       err;
  logic       stale;

  modport master (
    output seg_in,
    input  value,
    input  value_valid,
    input  err,
    input  stale
  );

  modport slave (
    input  seg_in,
    output value,
    output value_valid,
    output err,
    output stale
  );
endinterface

// File: rtl/seven_seg_rx.sv
// Decodes the two-digit multiplexed seven-segment bus back into an 8-bit value,
// with settle filtering, illegal-pattern reporting and a stale-bus timeout.
module seven_seg_rx #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          CLK,
  input  logic          RST,
  seven_seg_rx_if.slave bus
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      SETTLE_L  = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0]   TIMEOUT_L = TW'(TIMEOUT_CYCLES);

  typedef enum logic {
    WAIT_MSB = 1'b0,
    WAIT_LSB = 1'b1
  } state_t;

  logic [7:0]    s1_q, s1_d;
  logic [7:0]    s2_q, s2_d;
  logic [7:0]    stab_cnt_q, stab_cnt_d;
  logic          armed_q, armed_d;
  state_t        state_q, state_d;
  logic [3:0]    msb_q, msb_d;
  logic [7:0]    value_q, value_d;
  logic          value_valid_q, value_valid_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          capture;
  logic          publish;
  logic [4:0]    dec;
  logic          dec_legal;
  logic [3:0]    dec_nib;
  logic          dig_lsb;

  function automatic logic [7:0] sat_inc_settle(input logic [7:0] v);
    return (v >= SETTLE_L) ? SETTLE_L : v + 8'd1;
  endfunction

  function automatic logic [TW-1:0] sat_inc_tmo(input logic [TW-1:0] v);
    return (v >= TIMEOUT_L) ? TIMEOUT_L : v + TW'(1);
  endfunction

  // Returns {legal, nibble} for a lit-high segment pattern (bit0 = a .. bit6 = g).
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Input synchronizer and settle filter: one capture per stable period of s2.
  always_comb begin
    s1_d       = bus.seg_in;
    s2_d       = s1_q;
    stab_cnt_d = sat_inc_settle(stab_cnt_q);
    armed_d    = armed_q;
    capture    = 1'b0;
    if (s1_q != s2_q) begin
      stab_cnt_d = 8'd0;
      armed_d    = 1'b1;
    end else if (armed_q && (stab_cnt_d == SETTLE_L)) begin
      capture = 1'b1;
      armed_d = 1'b0;
    end
  end

  assign dec       = decode_seg(~s2_q[6:0]);
  assign dec_legal = dec[4];
  assign dec_nib   = dec[3:0];
  assign dig_lsb   = s2_q[7];

  // Frame assembly: an illegal capture always aborts the pending frame.
  always_comb begin
    state_d       = state_q;
    msb_d         = msb_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    err_d         = 1'b0;
    publish       = 1'b0;
    if (capture) begin
      if (!dec_legal) begin
        err_d   = 1'b1;
        msb_d   = 4'h0;
        state_d = WAIT_MSB;
      end else begin
        case (state_q)
          WAIT_MSB: begin
            if (!dig_lsb) begin
              msb_d   = dec_nib;
              state_d = WAIT_LSB;
            end
          end
          WAIT_LSB: begin
            if (!dig_lsb) begin
              msb_d = dec_nib;
            end else begin
              value_d       = {msb_q, dec_nib};
              value_valid_d = 1'b1;
              publish       = 1'b1;
              state_d       = WAIT_MSB;
            end
          end
          default: state_d = WAIT_MSB;
        endcase
      end
    end
    tmo_cnt_d = publish ? '0 : sat_inc_tmo(tmo_cnt_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q          <= 8'h00;
      s2_q          <= 8'h00;
      stab_cnt_q    <= 8'd0;
      armed_q       <= 1'b0;
      state_q       <= WAIT_MSB;
      msb_q         <= 4'h0;
      value_q       <= 8'h00;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stab_cnt_q    <= stab_cnt_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      msb_q         <= msb_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      err_q         <= err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.err         = err_q;
  assign bus.stale       = (tmo_cnt_q == TIMEOUT_L);

endmodule

// File: tb/tb_seven_seg_rx.sv
// Scoreboard bench for seven_seg_rx: a phase-level bus model predicts publish/err
// events and their cycles; a monitor compares outputs every cycle.
module tb_seven_seg_rx;
  localparam int S = 4;
  localparam int T = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seven_seg_rx_if bus ();

  seven_seg_rx #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [7:0] val;
  } ev_t;

  ev_t        q[$];
  logic [6:0] pats[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit         have_msb = 0;
  logic [3:0] msb = 4'h0;
  logic [7:0] prev_v = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  // Hold v on the bus for len edges; a phase of at least S+2 edges yields one capture.
  task automatic phase(input logic [7:0] v, input int len);
    int         c;
    int         n;
    ev_t        e;
    logic [6:0] lit;
    bus.seg_in = v;
    prev_v     = v;
    c          = cyc;
    if (len >= S + 2) begin
      lit = ~v[6:0];
      n   = decode(lit);
      e.cyc = c + S + 2;
      if (n < 0) begin
        e.is_err = 1'b1;
        e.val    = 8'h00;
        q.push_back(e);
        have_msb = 0;
      end else if (!v[7]) begin
        msb      = n[3:0];
        have_msb = 1;
      end else if (have_msb) begin
        e.is_err = 1'b0;
        e.val    = {msb, n[3:0]};
        q.push_back(e);
        have_msb = 0;
      end
    end
    repeat (len) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    have_msb = 0;
    prev_v   = 8'h00;
    chk("rst_value", bus.value, 8'h00);
    chk("rst_value_valid", bus.value_valid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_stale", bus.stale, 1'b0);
  endtask

  // Monitor: expected events are due at their cycle; stale follows the last publish/reset.
  logic [7:0] cur_val = 8'h00;
  int         base = 0;
  bit         r_edge;
  bit         e_vv, e_err;
  ev_t        e_m;
  initial begin
    forever begin
      @(posedge CLK);
      r_edge = RST;
      @(negedge CLK);
      if (r_edge) begin
        cur_val = 8'h00;
        base    = cyc;
      end
      e_vv  = 0;
      e_err = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e_m = q.pop_front();
        chk("event_overdue", 1, 0);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e_m = q.pop_front();
        if (e_m.is_err) e_err = 1;
        else begin
          e_vv    = 1;
          cur_val = e_m.val;
          base    = cyc;
        end
      end
      chk("value_valid", bus.value_valid, e_vv);
      chk("err", bus.err, e_err);
      chk("value", bus.value, cur_val);
      chk("stale", bus.stale, ((cyc - base) >= T) ? 1 : 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         len;
    int         k;
    bus.seg_in = 8'h00;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("init_value", bus.value, 8'h00);
    chk("init_stale", bus.stale, 1'b0);

    // Basic frame: '1' then '2' -> 8'h12
    phase(8'h79, 20);
    phase(8'hA4, 20);

    // Sweep all LSB digits under MSB '9'
    for (int i = 0; i < 16; i++) begin
      phase(8'h10, 10);
      v = {1'b1, ~pats[i]};
      phase(v, 10);
    end

    // Illegal blank LSB, then lone LSB, then a fresh pair
    phase(8'h79, 10);
    phase(8'hFF, 10);
    phase(8'hA4, 10);
    phase(8'h79, 10);
    phase(8'hA4, 10);

    // Glitch of '1' on the LSB digit while waiting for the LSB
    phase(8'h79, 10);
    phase(8'hA4, 2);
    phase(8'hF9, 3);
    phase(8'hA4, 10);

    // Stale after reset, cleared by a publish
    do_reset();
    phase(8'h79, 20);
    phase(8'hA4, 10);

    // Reset between MSB and LSB discards the MSB
    phase(8'h79, 10);
    do_reset();
    phase(8'hA4, 10);

    // Randomized phases
    for (int n = 0; n < 300; n++) begin
      do begin
        k = $urandom_range(0, 9);
        if (k < 4)      v = {1'b0, ~pats[$urandom_range(0, 15)]};
        else if (k < 8) v = {1'b1, ~pats[$urandom_range(0, 15)]};
        else            v = 8'($urandom_range(0, 255));
      end while (v == prev_v);
      if ($urandom_range(0, 9) < 3) len = $urandom_range(1, S - 1);
      else                          len = $urandom_range(S + 2, S + 12);
      phase(v, len);
      if ($urandom_range(0, 99) < 3) do_reset();
    end

    repeat (10) @(posedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
